// File: rtl/button_event_unit.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce FSM, pulse, sticky pending, press counter.
// Define BUTTON_ACTIVE_LOW_EN for pads that read 0 when pressed.
module button_event_unit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             button_raw_i,
  input  logic             ack_i,
  output logic             button_level_o,
  output logic             press_pulse_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] press_count_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic          pad;
  logic          sync_a;
  logic          sync;

`ifdef BUTTON_ACTIVE_LOW_EN
  assign pad = ~button_raw_i;
`else
  assign pad = button_raw_i;
`endif

  // Synchroniser holds the "pressed" polarity, so its released value is always 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_a <= 1'b0;
      sync   <= 1'b0;
    end else begin
      sync_a <= pad;
      sync   <= sync_a;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      cnt            <= '0;
      button_level_o <= 1'b0;
      press_pulse_o  <= 1'b0;
      pending_o      <= 1'b0;
      press_count_o  <= '0;
    end else begin
      press_pulse_o <= 1'b0;
      if (ack_i)
        pending_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= DW'(1);
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            // Later assignment wins over the ack clear above, so a press is never lost.
            state          <= PRESSED;
            cnt            <= '0;
            button_level_o <= 1'b1;
            press_pulse_o  <= 1'b1;
            pending_o      <= 1'b1;
            press_count_o  <= press_count_o + CNT_W'(1);
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= DW'(1);
          end else begin
            cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state          <= IDLE;
            cnt            <= '0;
            button_level_o <= 1'b0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_unit.sv
// Bench for button_event_unit: directed test-plan steps plus random bounce runs against a run-length debounce model.
module tb_button_event_unit;

  localparam int D = 4;
  localparam int CW = 4;
`ifdef BUTTON_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          button_raw_i = INV;
  logic          ack_i = 1'b0;
  logic          button_level_o;
  logic          press_pulse_o;
  logic          pending_o;
  logic [CW-1:0] press_count_o;

  button_event_unit #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .button_raw_i(button_raw_i), .ack_i(ack_i),
    .button_level_o(button_level_o), .press_pulse_o(press_pulse_o),
    .pending_o(pending_o), .press_count_o(press_count_o)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // Model: the FSM sees the pressed-level sampled two edges earlier; the level flips
  // once that delayed sample has disagreed with it on D consecutive edges.
  bit          hist [2];
  bit          m_level;
  int          m_run;
  bit          m_pulse;
  bit          m_pending;
  logic [CW-1:0] m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist[0] = 0; hist[1] = 0;
    m_level = 0; m_run = 0; m_pulse = 0; m_pending = 0; m_count = '0;
  endtask

  task automatic model_edge(input bit pressed, input bit ack);
    bit seen;
    bit accept;
    seen   = hist[1];
    hist[1] = hist[0];
    hist[0] = pressed;
    accept = 0;
    if (seen != m_level) m_run++;
    else m_run = 0;
    if (m_run == D) begin
      m_level = ~m_level;
      m_run = 0;
      accept = m_level;
    end
    m_pulse = accept;
    if (accept) m_pending = 1;
    else if (ack) m_pending = 0;
    if (accept) m_count = m_count + 1'b1;
  endtask

  task automatic compare_model();
    check("level", {31'd0, button_level_o}, {31'd0, m_level});
    check("pulse", {31'd0, press_pulse_o}, {31'd0, m_pulse});
    check("pending", {31'd0, pending_o}, {31'd0, m_pending});
    check("count", {28'd0, press_count_o}, {28'd0, m_count});
  endtask

  task automatic step(input bit pressed, input bit ack);
    button_raw_i = pressed ^ INV;
    ack_i = ack;
    @(posedge CLK);
    model_edge(pressed, ack);
    #1;
    compare_model();
  endtask

  task automatic steps(input int n, input bit pressed);
    for (int i = 0; i < n; i++) step(pressed, 1'b0);
  endtask

  // Asserted mid-cycle so the all-zero check proves the reset is asynchronous.
  task automatic do_reset(input string tag);
    #2;
    RST = 1'b0;
    #1;
    check({tag, "_level"}, {31'd0, button_level_o}, 32'd0);
    check({tag, "_pulse"}, {31'd0, press_pulse_o}, 32'd0);
    check({tag, "_pending"}, {31'd0, pending_o}, 32'd0);
    check({tag, "_count"}, {28'd0, press_count_o}, 32'd0);
    model_reset();
    @(posedge CLK);
    #3;
    RST = 1'b1;
  endtask

  // Holding pressed from released: level is 0 through the 5th edge, 1 on the 6th (2 sync + D).
  task automatic press_latency(input string tag, input logic [CW-1:0] exp_count);
    steps(5, 1'b1);
    check({tag, "_early"}, {31'd0, button_level_o}, 32'd0);
    step(1'b1, 1'b0);
    check({tag, "_level"}, {31'd0, button_level_o}, 32'd1);
    check({tag, "_pulse"}, {31'd0, press_pulse_o}, 32'd1);
    check({tag, "_pending"}, {31'd0, pending_o}, 32'd1);
    check({tag, "_count"}, {28'd0, press_count_o}, {28'd0, exp_count});
    step(1'b1, 1'b0);
    check({tag, "_pulse_end"}, {31'd0, press_pulse_o}, 32'd0);
  endtask

  initial begin
    model_reset();
    #2;
    check("rst_level", {31'd0, button_level_o}, 32'd0);
    check("rst_pulse", {31'd0, press_pulse_o}, 32'd0);
    check("rst_pending", {31'd0, pending_o}, 32'd0);
    check("rst_count", {28'd0, press_count_o}, 32'd0);
    @(posedge CLK);
    #3;
    RST = 1'b1;

    steps(3, 1'b1);
    steps(8, 1'b0);
    check("glitch_level", {31'd0, button_level_o}, 32'd0);
    check("glitch_count", {28'd0, press_count_o}, 32'd0);

    press_latency("press", 4'd1);
    steps(2, 1'b1);
    steps(3, 1'b0);
    steps(8, 1'b1);
    check("rel_glitch_level", {31'd0, button_level_o}, 32'd1);

    step(1'b1, 1'b1);
    check("ack_clear", {31'd0, pending_o}, 32'd0);
    steps(5, 1'b1);
    steps(5, 1'b0);
    check("rel_early", {31'd0, button_level_o}, 32'd1);
    step(1'b0, 1'b0);
    check("rel_level", {31'd0, button_level_o}, 32'd0);
    steps(4, 1'b0);

    steps(5, 1'b1);
    step(1'b1, 1'b1);
    check("ack_vs_set", {31'd0, pending_o}, 32'd1);
    check("ack_vs_set_count", {28'd0, press_count_o}, 32'd2);
    steps(10, 1'b0);

    steps(3, 1'b1);
    do_reset("rst_wait");
    press_latency("after_rst_wait", 4'd1);
    do_reset("rst_pressed");
    press_latency("after_rst_pressed", 4'd1);

    steps(10, 1'b0);
    do_reset("rst_wrap");
    for (int i = 0; i < 16; i++) begin
      steps(8, 1'b1);
      steps(8, 1'b0);
    end
    check("wrap_count", {28'd0, press_count_o}, 32'd0);
    steps(8, 1'b1);
    check("wrap_plus1", {28'd0, press_count_o}, 32'd1);

    for (int r = 0; r < 150; r++) begin
      int len;
      bit lvl;
      len = $urandom_range(1, 12);
      lvl = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++)
        step(lvl, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_event_unit.md
# button_event_unit

Conditions the raw board push-button before it reaches the data memory manager's `button_i` input and its memory-mapped button register. Synchronises the asynchronous pad signal, debounces it with a press/release state machine, and produces:
- a clean level;
- a one-cycle press pulse;
- a sticky pending flag that the CPU clears by reading;
- a wrapping press counter.

Lives in the micro top level between the board pin and the data memory manager, clocked by the CPU clock.

## Interface
- `DEBOUNCE_CYCLES`, 50000, consecutive stable synchronised cycles required to accept a level change (≥ 2).
- `CNT_W`, 16, width of the press counter.
- `CLK` input 1: CPU clock; all state on rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `button_raw_i` input 1: raw pad signal, asynchronous to `CLK`.
- `ack_i` input 1: read-clear strobe from the data memory manager; clears pending.
- `button_level_o` output 1: debounced level, 1 = pressed.
- `press_pulse_o` output 1: high for exactly one cycle per accepted press.
- `pending_o` output 1: sticky "press occurred since last ack".
- `press_count_o` output `CNT_W`: accepted presses since reset, wraps.

## Operation
- **Input path:** two-flop synchroniser on `button_raw_i` (after optional inversion, see Configuration). The synchronised value is `sync`.
- **Debounce counter:** width = clog2(`DEBOUNCE_CYCLES`).
  - Cleared whenever the state machine is in a stable state and `sync` equals the current level.
  - Otherwise increments each cycle.
- **FSM states:** IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
- **IDLE:**
  - `sync`=1 → PRESS_WAIT, counter=1.
- **PRESS_WAIT:**
  - `sync`=0 → IDLE, counter=0 (glitch rejected; no event).
  - Counter reaches `DEBOUNCE_CYCLES`-1 while `sync`=1 → PRESSED. In that transition cycle:
    - `button_level_o`←1;
    - `press_pulse_o`←1 for the following cycle;
    - `pending_o`←1;
    - `press_count_o` increments.
- **PRESSED:**
  - `sync`=0 → RELEASE_WAIT, counter=1.
- **RELEASE_WAIT:**
  - `sync`=1 → PRESSED, counter=0 (no event).
  - Counter reaches `DEBOUNCE_CYCLES`-1 while `sync`=0 → IDLE, `button_level_o`←0. No pulse on release.
- **`pending_o`:**
  - Set by an accepted press, cleared by `ack_i`.
  - Press acceptance and `ack_i` in the same cycle → `pending_o` stays/becomes 1 (set wins; the new press is not lost).
  - `ack_i` with `pending_o`=0 has no effect.
- **`press_count_o`:** modulo 2^`CNT_W`; all-ones + 1 → 0.
- All outputs are registered; none depends combinationally on inputs.

## Timing
- **Reset (`RST`=0, asynchronous):**
  - synchroniser flops = released level;
  - state = IDLE, counter = 0;
  - `button_level_o`=0, `press_pulse_o`=0, `pending_o`=0, `press_count_o`=0.
- **Reset deassertion:** takes effect on the next `CLK` rising edge.
- **Reset mid-debounce or while pressed:** everything returns to reset values.
  - If the button is still held after reset release, a fresh press is accepted after the full latency. This does not reflect the raw level immediately.
- **Press latency:** from the first `CLK` edge sampling the new raw level to `button_level_o`=1 = 2 (sync) + `DEBOUNCE_CYCLES` cycles.
  - `press_pulse_o`, `pending_o` and `press_count_o` update in the same cycle as `button_level_o`.
- **Release latency:** identical, 2 + `DEBOUNCE_CYCLES` cycles.
- **Minimum spacing between two press pulses:** 2·`DEBOUNCE_CYCLES` cycles.
- **`ack_i`:** sampled on the rising edge; `pending_o` low the next cycle.

## Configuration
- Macro `BUTTON_ACTIVE_LOW_EN`.
  - **Defined:** `button_raw_i` is inverted before the synchroniser (pad 0 = pressed, matching the board keys).
    - Synchroniser reset value corresponds to pad = 1.
  - **Not defined:** pad 1 = pressed, synchroniser resets to 0.
  - All other behaviour is identical.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `CNT_W`=4, macro undefined unless stated.
- **Clean press:** raw 0→1 held 10 cycles → `button_level_o` rises exactly 6 cycles after the first sampling edge; `press_pulse_o` high 1 cycle; `pending_o`=1; count=1.
- **Glitch rejection:** raw high for 3 cycles, then low → no pulse, level stays 0, count=0.
  - Same test while pressed: raw low for 3 cycles → level stays 1, no release.
- **Pending and ack:**
  - Press, then `ack_i` one cycle → `pending_o`=0 next cycle.
  - Press acceptance coincident with `ack_i` → `pending_o`=1.
- **Counter wrap:** 16 clean press/release pairs → count returns to 0; 17th press → 1.
- **Reset mid-operation:** assert `RST`=0 during PRESS_WAIT and during PRESSED → all outputs 0 immediately (asynchronously); raw held high through release → new press accepted 6 cycles after reset release, count=1.
- **Active-low build** (`BUTTON_ACTIVE_LOW_EN` defined): raw idles 1, drive 0 held → level=1 after 6 cycles; raw back to 1 → level=0 after 6 cycles.
